// File: rtl/cci_mpf_prim_pkg.sv
// Shared types for the CCI-MPF primitive library.
package cci_mpf_prim_pkg;

   // Write-arbitrated LUTRAM controller states: table initialization, then normal operation.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } t_lutram_arb_state;

endpackage : cci_mpf_prim_pkg

// File: rtl/cci_mpf_prim_lutram.sv
// Single-write-port LUTRAM with an asynchronous (combinational) read port.
module cci_mpf_prim_lutram #(
   parameter int unsigned N_ENTRIES   = 32,
   parameter int unsigned N_DATA_BITS = 64
) (
   input  logic                           clk,
   input  logic                           wen,
   input  logic [$clog2(N_ENTRIES)-1:0]   waddr,
   input  logic [N_DATA_BITS-1:0]         wdata,
   input  logic [$clog2(N_ENTRIES)-1:0]   raddr,
   output logic [N_DATA_BITS-1:0]         rdata
);

   logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];

   // Storage write; new contents become visible on the read port after the edge.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : cci_mpf_prim_lutram

// File: rtl/cci_mpf_prim_lutram_wr_arb.sv
// LUTRAM with N round-robin-arbitrated write ports and post-reset table initialization.
// Optional feature: define CCI_MPF_PRIM_LUTRAM_WR_ARB_CONFLICT_EN to build the
// same-address write collision detector driving wr_conflict.
module cci_mpf_prim_lutram_wr_arb
   import cci_mpf_prim_pkg::*;
#(
   parameter int unsigned             N_ENTRIES   = 32,
   parameter int unsigned             N_DATA_BITS = 64,
   parameter int unsigned             N_WRITERS   = 4,
   parameter logic [N_DATA_BITS-1:0]  INIT_VALUE  = N_DATA_BITS'(0)
) (
   input  logic                                          clk,
   input  logic                                          reset,
   output logic                                          rdy,
   input  logic [N_WRITERS-1:0]                          wr_req,
   input  logic [N_WRITERS-1:0][$clog2(N_ENTRIES)-1:0]   wr_addr,
   input  logic [N_WRITERS-1:0][N_DATA_BITS-1:0]         wr_data,
   output logic [N_WRITERS-1:0]                          wr_grant,
   input  logic [$clog2(N_ENTRIES)-1:0]                  raddr,
   output logic [N_DATA_BITS-1:0]                        rdata,
   output logic                                          wr_conflict
);

   localparam int unsigned A_W   = $clog2(N_ENTRIES);
   localparam int unsigned IDX_W = $clog2(N_WRITERS);

   t_lutram_arb_state      state_q;
   logic [A_W-1:0]         init_ctr_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [IDX_W-1:0]       rr_ptr_d;
   logic                   rdy_q;

   logic [N_WRITERS-1:0]   grant_c;
   logic [IDX_W-1:0]       grant_idx_c;
   logic                   grant_vld_c;

   logic                   wen_c;
   logic [A_W-1:0]         waddr_c;
   logic [N_DATA_BITS-1:0] wdata_c;

   // Round-robin arbiter: first requester at or after rr_ptr, wrapping; no grants during INIT.
   always_comb begin
      int unsigned scan_idx;
      grant_c     = '0;
      grant_idx_c = '0;
      grant_vld_c = 1'b0;
      scan_idx    = 0;
      if (state_q == RUN) begin
         for (int unsigned k = 0; k < N_WRITERS; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= N_WRITERS) begin
               scan_idx = scan_idx - N_WRITERS;
            end
            if (!grant_vld_c && wr_req[IDX_W'(scan_idx)]) begin
               grant_vld_c = 1'b1;
               grant_idx_c = IDX_W'(scan_idx);
            end
         end
         if (grant_vld_c) begin
            grant_c[grant_idx_c] = 1'b1;
         end
      end
   end

   // Pointer moves to the writer just after the one granted.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld_c) begin
         rr_ptr_d = (grant_idx_c == IDX_W'(N_WRITERS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
      end
   end

   // Write-port mux: init sweep owns the port in INIT, the granted writer in RUN.
   always_comb begin
      wen_c   = 1'b0;
      waddr_c = init_ctr_q;
      wdata_c = INIT_VALUE;
      if (state_q == INIT) begin
         wen_c = 1'b1;
      end else if (grant_vld_c) begin
         wen_c   = 1'b1;
         waddr_c = wr_addr[grant_idx_c];
         wdata_c = wr_data[grant_idx_c];
      end
   end

   // Control FSM: sweep every entry once after reset, then arbitrate writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_ctr_q <= '0;
         rr_ptr_q   <= '0;
         rdy_q      <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               init_ctr_q <= init_ctr_q + A_W'(1);
               if (init_ctr_q == A_W'(N_ENTRIES - 1)) begin
                  state_q <= RUN;
                  rdy_q   <= 1'b1;
               end
            end
            RUN: begin
               rr_ptr_q <= rr_ptr_d;
            end
            default: begin
               state_q <= INIT;
            end
         endcase
      end
   end

`ifdef CCI_MPF_PRIM_LUTRAM_WR_ARB_CONFLICT_EN
   logic conflict_c;
   logic conflict_q;

   // Any pair of active requesters targeting the same entry.
   always_comb begin
      conflict_c = 1'b0;
      for (int unsigned i = 0; i < N_WRITERS; i++) begin
         for (int unsigned j = i + 1; j < N_WRITERS; j++) begin
            if (wr_req[IDX_W'(i)] && wr_req[IDX_W'(j)] &&
                (wr_addr[IDX_W'(i)] == wr_addr[IDX_W'(j)])) begin
               conflict_c = 1'b1;
            end
         end
      end
   end

   // One-cycle-late collision flag, only meaningful while running.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= (state_q == RUN) && conflict_c;
      end
   end

   assign wr_conflict = conflict_q;
`else
   assign wr_conflict = 1'b0;
`endif

   cci_mpf_prim_lutram #(
      .N_ENTRIES   (N_ENTRIES),
      .N_DATA_BITS (N_DATA_BITS)
   ) u_mem (
      .clk   (clk),
      .wen   (wen_c),
      .waddr (waddr_c),
      .wdata (wdata_c),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign rdy      = rdy_q;
   assign wr_grant = grant_c;

endmodule : cci_mpf_prim_lutram_wr_arb

// File: tb/tb_cci_mpf_prim_lutram_wr_arb.sv
// Self-checking bench for cci_mpf_prim_lutram_wr_arb (default parameters).
module tb_cci_mpf_prim_lutram_wr_arb;

   localparam int unsigned NE = 32;
   localparam int unsigned NW = 4;
   localparam int unsigned DW = 64;
   localparam logic [DW-1:0] IV = 64'h0;

`ifdef CCI_MPF_PRIM_LUTRAM_WR_ARB_CONFLICT_EN
   localparam logic EXP_CONF = 1'b1;
`else
   localparam logic EXP_CONF = 1'b0;
`endif

   logic                    clk;
   logic                    reset;
   logic                    rdy;
   logic [NW-1:0]           wr_req;
   logic [NW-1:0][4:0]      wr_addr;
   logic [NW-1:0][DW-1:0]   wr_data;
   logic [NW-1:0]           wr_grant;
   logic [4:0]              raddr;
   logic [DW-1:0]           rdata;
   logic                    wr_conflict;

   int total;
   int bad;

   logic [DW-1:0] m_mem [NE];
   int            m_rr;
   logic [NW-1:0] exp_grant_q [$];
   logic [DW-1:0] exp_rdata_q [$];

   cci_mpf_prim_lutram_wr_arb #(
      .N_ENTRIES   (NE),
      .N_DATA_BITS (DW),
      .N_WRITERS   (NW),
      .INIT_VALUE  (IV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rdy         (rdy),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_grant    (wr_grant),
      .raddr       (raddr),
      .rdata       (rdata),
      .wr_conflict (wr_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [NW-1:0] model_grant(input logic [NW-1:0] req, input int rr);
      for (int k = 0; k < NW; k++) begin
         int idx;
         idx = (rr + k) % NW;
         if (req[idx]) return NW'(1) << idx;
      end
      return '0;
   endfunction

   function automatic int onehot_idx(input logic [NW-1:0] g);
      for (int i = 0; i < NW; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_init();
      for (int a = 0; a < NE; a++) m_mem[a] = IV;
      m_rr = 0;
   endtask

   task automatic model_write(input logic [NW-1:0] g);
      int i;
      if (g != '0) begin
         i = onehot_idx(g);
         m_mem[wr_addr[i]] = wr_data[i];
         m_rr = (i + 1) % NW;
      end
   endtask

   // Reset, run the init sweep and wait (bounded) for rdy.
   task automatic do_reset_init();
      bit seen;
      seen   = 0;
      reset  = 1'b1;
      wr_req = '0;
      step();
      step();
      reset = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (rdy === 1'b1) seen = 1;
         step();
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL init_timeout: rdy never rose, rdy=%b required 1", rdy);
      end
      model_init();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      wr_req  = '1;
      wr_addr = '0;
      wr_data = '0;
      raddr   = '0;
      step();
      step();
      step();
      @(negedge clk);
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b exp 0", rdy); end
      total++;
      if (wr_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b exp 0000", wr_grant); end
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict: got %b exp 0", wr_conflict); end
      step();
   endtask

   // Requests held through INIT are ignored; rdy rises on cycle 33; first grant goes to writer 0.
   task automatic test_init_grant();
      reset = 1'b0;
      for (int c = 0; c < NE; c++) begin
         @(negedge clk);
         total++;
         if (rdy !== 1'b0) begin bad++; $display("FAIL init_rdy[%0d]: got %b exp 0", c, rdy); end
         total++;
         if (wr_grant !== 4'b0000) begin bad++; $display("FAIL init_grant[%0d]: got %b exp 0000", c, wr_grant); end
         step();
      end
      @(negedge clk);
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL init_rdy_rise: got %b exp 1", rdy); end
      total++;
      if (wr_grant !== 4'b0001) begin bad++; $display("FAIL first_grant: got %b exp 0001", wr_grant); end
      model_init();
      model_write(4'b0001);
      step();
      wr_req = '0;
   endtask

   task automatic test_readback();
      for (int a = 0; a < NE; a++) begin
         raddr = 5'(a);
         @(negedge clk);
         total++;
         if (rdata !== m_mem[a]) begin bad++; $display("FAIL readback[%0d]: got %h exp %h", a, rdata, m_mem[a]); end
         step();
      end
   endtask

   task automatic test_round_robin();
      logic [NW-1:0] rr_exp [8];
      logic [NW-1:0] e;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      do_reset_init();
      for (int c = 0; c < 8; c++) begin
         wr_req = '1;
         for (int i = 0; i < NW; i++) begin
            wr_addr[i] = 5'(8 + i);
            wr_data[i] = 64'(c * 256 + i + 1);
         end
         exp_grant_q.push_back(rr_exp[c]);
         @(negedge clk);
         e = exp_grant_q.pop_front();
         total++;
         if (wr_grant !== e) begin bad++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, wr_grant, e); end
         model_write(e);
         step();
      end
      wr_req = '0;
      for (int i = 0; i < NW; i++) begin
         raddr = 5'(8 + i);
         @(negedge clk);
         total++;
         if (rdata !== m_mem[8 + i]) begin bad++; $display("FAIL rr_data[%0d]: got %h exp %h", i, rdata, m_mem[8 + i]); end
         step();
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] old_v;
      old_v      = m_mem[5];
      wr_req     = 4'b0100;
      wr_addr[2] = 5'd5;
      wr_data[2] = 64'hABCD;
      raddr      = 5'd5;
      @(negedge clk);
      total++;
      if (wr_grant !== 4'b0100) begin bad++; $display("FAIL byp_grant: got %b exp 0100", wr_grant); end
      total++;
      if (rdata !== old_v) begin bad++; $display("FAIL byp_old: got %h exp %h", rdata, old_v); end
      model_write(4'b0100);
      step();
      wr_req = '0;
      @(negedge clk);
      total++;
      if (rdata !== 64'hABCD) begin bad++; $display("FAIL byp_new: got %h exp abcd", rdata); end
      step();
   endtask

   // Random held-until-granted writers checked against the arbiter/memory model.
   task automatic test_random();
      logic [NW-1:0] pend;
      logic [NW-1:0] g;
      logic [NW-1:0] eg;
      logic [DW-1:0] ed;
      pend = '0;
      for (int c = 0; c < 80; c++) begin
         for (int i = 0; i < NW; i++) begin
            if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
               pend[i]    = 1'b1;
               wr_addr[i] = 5'($urandom_range(0, 7));
               wr_data[i] = {$urandom, $urandom};
            end
         end
         wr_req = pend;
         raddr  = 5'($urandom_range(0, 7));
         g      = model_grant(pend, m_rr);
         exp_grant_q.push_back(g);
         exp_rdata_q.push_back(m_mem[raddr]);
         @(negedge clk);
         eg = exp_grant_q.pop_front();
         ed = exp_rdata_q.pop_front();
         total++;
         if (wr_grant !== eg) begin bad++; $display("FAIL rnd_grant[%0d]: got %b exp %b", c, wr_grant, eg); end
         total++;
         if (rdata !== ed) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", c, rdata, ed); end
         model_write(eg);
         pend = pend & ~eg;
         step();
      end
      wr_req = '0;
   endtask

   task automatic test_conflict();
      logic [NW-1:0] g;
      logic [NW-1:0] rem;
      wr_req     = 4'b1001;
      wr_addr[0] = 5'd7;
      wr_addr[3] = 5'd7;
      wr_data[0] = 64'h1111;
      wr_data[3] = 64'h3333;
      g = model_grant(wr_req, m_rr);
      @(negedge clk);
      total++;
      if (wr_grant !== g) begin bad++; $display("FAIL conf_grant: got %b exp %b", wr_grant, g); end
      model_write(g);
      step();
      rem    = 4'b1001 & ~g;
      wr_req = rem;
      @(negedge clk);
      total++;
      if (wr_conflict !== EXP_CONF) begin bad++; $display("FAIL conf_flag: got %b exp %b", wr_conflict, EXP_CONF); end
      total++;
      if (wr_grant !== rem) begin bad++; $display("FAIL conf_grant2: got %b exp %b", wr_grant, rem); end
      model_write(rem);
      step();
      wr_req = '0;
      @(negedge clk);
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conf_clear: got %b exp 0", wr_conflict); end
      step();
      wr_req     = 4'b1001;
      wr_addr[3] = 5'd8;
      g = model_grant(wr_req, m_rr);
      @(negedge clk);
      model_write(g);
      step();
      wr_req = 4'b1001 & ~g;
      @(negedge clk);
      total++;
      if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conf_distinct: got %b exp 0", wr_conflict); end
      model_write(wr_req);
      step();
      wr_req = '0;
   endtask

   task automatic test_reset_mid_init();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) step();
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL mid_init_rdy: got %b exp 0", rdy); end
      step();
      reset = 1'b0;
      for (int c = 0; c < NE; c++) begin
         @(negedge clk);
         total++;
         if (rdy !== 1'b0) begin bad++; $display("FAIL reinit_rdy[%0d]: got %b exp 0", c, rdy); end
         step();
      end
      @(negedge clk);
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL reinit_rise: got %b exp 1", rdy); end
      model_init();
      step();
      for (int k = 0; k < 3; k++) begin
         logic [4:0] a;
         a     = (k == 0) ? 5'd5 : ((k == 1) ? 5'd7 : 5'd8);
         raddr = a;
         @(negedge clk);
         total++;
         if (rdata !== IV) begin bad++; $display("FAIL reinit_data[%0d]: got %h exp %h", a, rdata, IV); end
         step();
      end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      wr_req = 4'b0010;
      @(negedge clk);
      total++;
      if (wr_grant !== 4'b0010) begin bad++; $display("FAIL run_pre_grant: got %b exp 0010", wr_grant); end
      step();
      wr_req = '1;
      reset  = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (wr_grant !== 4'b0000) begin bad++; $display("FAIL run_rst_grant: got %b exp 0000", wr_grant); end
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL run_rst_rdy: got %b exp 0", rdy); end
      step();
      reset = 1'b0;
      seen  = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            seen = 1;
            total++;
            if (wr_grant !== 4'b0001) begin bad++; $display("FAIL run_rst_ptr: got %b exp 0001", wr_grant); end
         end
         step();
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL run_rst_timeout: rdy=%b required 1", rdy);
      end
      wr_req = '0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_init_grant();
      test_readback();
      test_round_robin();
      test_bypass();
      test_random();
      test_conflict();
      test_reset_mid_init();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cci_mpf_prim_lutram_wr_arb

// File: doc/cci_mpf_prim_lutram_wr_arb.md
CCI_MPF_PRIM_LUTRAM_WR_ARB -- requirements
Module: cci_mpf_prim_lutram_wr_arb

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 32, meaning table depth (power of 2, >=2).
REQ-002 SHALL have parameter N_DATA_BITS, default 64, meaning entry width.
REQ-003 SHALL have parameter N_WRITERS, default 4, meaning number of write requesters (>=2).
REQ-004 SHALL have parameter INIT_VALUE, default N_DATA_BITS'(0), meaning value written to every entry after reset.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-007 SHALL have port rdy, output, 1, high once initialization is complete.
REQ-008 SHALL have port wr_req, input, N_WRITERS, per-writer write request (held until granted).
REQ-009 SHALL have port wr_addr, input, N_WRITERS x $clog2(N_ENTRIES), per-writer address.
REQ-010 SHALL have port wr_data, input, N_WRITERS x N_DATA_BITS, per-writer data.
REQ-011 SHALL have port wr_grant, output, N_WRITERS, one-hot-or-zero grant.
REQ-012 SHALL have port raddr, input, $clog2(N_ENTRIES), read address.
REQ-013 SHALL have port rdata, output, N_DATA_BITS, combinational read data.
REQ-014 SHALL have port wr_conflict, output, 1, same-address collision flag.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-016 In INIT, SHALL write INIT_VALUE to address init_ctr each cycle, incrementing from 0; after address N_ENTRIES-1 is written, SHALL enter RUN.
REQ-017 rdy SHALL be 0 in INIT and rise in the cycle after the last init write, then stay 1 until reset.
REQ-018 wr_grant SHALL be all-zero in INIT regardless of wr_req.
REQ-019 In RUN, wr_grant SHALL be combinational from wr_req and a round-robin pointer; at most one bit set.
REQ-020 Priority SHALL begin at index rr_ptr and wrap modulo N_WRITERS; after granting writer i, rr_ptr SHALL become (i+1) mod N_WRITERS; rr_ptr unchanged when no grant.
REQ-021 The granted writer's wr_addr/wr_data SHALL be written in the grant cycle; a writer observing wr_grant SHALL deassert or present a new request next cycle.
REQ-022 rdata SHALL return the value at raddr; a read of an address in its grant cycle returns the old value; from the following cycle it SHALL return the new value (bypass included).
REQ-023 With all N_WRITERS requesting continuously, each writer SHALL be granted exactly once per N_WRITERS cycles.
REQ-024 Reset asserted mid-INIT or mid-RUN SHALL restart INIT at address 0, clear rr_ptr, and drop all grants the following cycle.

Reset
REQ-025 On reset: state=INIT, init_ctr=0, rr_ptr=0, rdy=0, wr_conflict=0; wr_grant=0 (follows from INIT).
REQ-026 Table contents SHALL be undefined until rdy=1.

Configuration
REQ-027 With CCI_MPF_PRIM_LUTRAM_WR_ARB_CONFLICT_EN defined, wr_conflict SHALL be registered and pulse 1 cycle after any RUN cycle where two or more asserted wr_req share the same wr_addr.
REQ-028 Without CCI_MPF_PRIM_LUTRAM_WR_ARB_CONFLICT_EN, wr_conflict SHALL be tied 0 and no comparator logic is built; arbitration unaffected in both cases.

Structure
REQ-029 SHALL instantiate exactly one sub-module, cci_mpf_prim_lutram, as storage; init mux and arbiter live in this module.
REQ-030 FSM state enum (t_lutram_arb_state: INIT, RUN) SHALL reside in shared package cci_mpf_prim_pkg; widths derive from parameters locally.

Verification
REQ-031 Reset, N_ENTRIES=32 -> rdy=0 for 32 cycles, rdy=1 on cycle 33; all 32 reads return INIT_VALUE.
REQ-032 wr_req=4'b1111 held during INIT -> wr_grant=0 throughout; first RUN grant is 4'b0001.
REQ-033 wr_req=4'b1111 held 8 RUN cycles -> grants 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-034 Writer 2 writes addr 5 = 0xABCD; raddr=5 -> old value in grant cycle, 0xABCD next cycle.
REQ-035 Writers 0 and 3 both request addr 7 (macro defined) -> wr_conflict=1 one cycle later; macro undefined -> stays 0.
REQ-036 Reset asserted at init_ctr=10 -> rdy stays 0, init restarts at 0, rdy rises 32 cycles after reset release.
